// File: rtl/axi4_lite_reg_slv_if.sv
// AXI4-Lite bus bundle for the axi4_lite_reg_slv register block.
// The master modport is the bus driver side, the slave modport is the register block.
interface axi4_lite_reg_slv_if #(
  parameter int AW = 8,
  parameter int DW = 32
) ();
  logic [AW-1:0]   s_awaddr;
  logic            s_awvalid;
  logic            s_awready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wvalid;
  logic            s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready;
  logic [AW-1:0]   s_araddr;
  logic            s_arvalid;
  logic            s_arready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rvalid;
  logic            s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi4_lite_reg_slv.sv
// AXI4-Lite slave with four 32-bit registers: CTRL (0x0), STATUS (0x4), COUNT (0x8), SCRATCH (0xC).
// Optional macro AXI4_LITE_REG_SLV_SLVERR_EN: unmapped accesses answer SLVERR instead of OKAY.
module axi4_lite_reg_slv #(
  parameter int ADDR_BIT_WIDTH = 8,
  parameter int DATA_BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi4_lite_reg_slv_if.slave   s_axi,
  input  logic [31:0]          status_i,
  output logic                 cnt_wrap_o
);

  if (DATA_BIT_WIDTH != 32) begin : g_bad_data_width
    $error("axi4_lite_reg_slv: DATA_BIT_WIDTH must be 32");
  end

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI4_LITE_REG_SLV_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_UNMAPPED = RESP_OKAY;
`endif

  // The write executes on the edge where the later of AW/W completes, so no
  // separate execute cycle is spent between capture and response.
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_RESP} rd_state_e;

  wr_state_e                 wst_q, wst_d;
  rd_state_e                 rst_q, rst_d;
  logic                      rdy_en_q;
  logic                      aw_held_q, aw_held_d;
  logic [ADDR_BIT_WIDTH-1:2] awaddr_q, awaddr_d;
  logic                      w_held_q, w_held_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic                      do_write;
  logic [1:0]                bresp_q, bresp_d;
  logic                      ctrl_en_q, ctrl_en_d;
  logic [31:0]               count_q, count_d;
  logic [31:0]               scratch_q, scratch_d;
  logic                      wrap_q, wrap_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      aw_hs, w_hs, ar_hs;
  logic                      wr_mapped, rd_mapped;
  logic                      wr_count, cnt_clr;
  logic                      unused_addr_lsb;

  // Byte lanes with strobe 0 keep the old value.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  assign aw_hs = s_axi.s_awvalid && s_axi.s_awready;
  assign w_hs  = s_axi.s_wvalid  && s_axi.s_wready;
  assign ar_hs = s_axi.s_arvalid && s_axi.s_arready;
  assign unused_addr_lsb = ^{s_axi.s_awaddr[1:0], s_axi.s_araddr[1:0]};

  // State and storage registers; readies stay low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wst_q     <= W_IDLE;
      rst_q     <= R_IDLE;
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      ctrl_en_q <= 1'b0;
      count_q   <= '0;
      scratch_q <= '0;
      wrap_q    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      wst_q     <= wst_d;
      rst_q     <= rst_d;
      rdy_en_q  <= 1'b1;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      ctrl_en_q <= ctrl_en_d;
      count_q   <= count_d;
      scratch_q <= scratch_d;
      wrap_q    <= wrap_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Write FSM next state: collect AW and W in any order, fire once both are held.
  always_comb begin
    wst_d     = wst_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    do_write  = 1'b0;
    case (wst_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.s_awaddr[ADDR_BIT_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.s_wdata;
          wstrb_d  = s_axi.s_wstrb;
        end
        if (aw_held_d && w_held_d) begin
          do_write  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wst_d     = W_RESP;
        end
      end
      W_RESP:  if (s_axi.s_bready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  // Register file update: a COUNT write beats cnt_clr, which beats the increment.
  always_comb begin
    ctrl_en_d = ctrl_en_q;
    count_d   = count_q;
    scratch_d = scratch_q;
    bresp_d   = bresp_q;
    wrap_d    = 1'b0;
    wr_count  = 1'b0;
    cnt_clr   = 1'b0;
    wr_mapped = (awaddr_d[ADDR_BIT_WIDTH-1:4] == '0);
    if (do_write) begin
      bresp_d = wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
      if (wr_mapped) begin
        case (awaddr_d[3:2])
          2'd0: if (wstrb_d[0]) begin
            ctrl_en_d = wdata_d[0];
            cnt_clr   = wdata_d[1];
          end
          2'd2:    wr_count  = 1'b1;
          2'd3:    scratch_d = strb_merge(scratch_q, wdata_d, wstrb_d);
          default: ;
        endcase
      end
    end
    if (wr_count) begin
      count_d = strb_merge(count_q, wdata_d, wstrb_d);
    end else if (cnt_clr) begin
      count_d = '0;
    end else if (ctrl_en_q) begin
      count_d = count_q + 32'd1;
      wrap_d  = &count_q;
    end
  end

  // Read FSM next state: capture the addressed register at the AR handshake.
  always_comb begin
    rst_d     = rst_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_mapped = (s_axi.s_araddr[ADDR_BIT_WIDTH-1:4] == '0);
    case (rst_q)
      R_IDLE: if (ar_hs) begin
        rst_d = R_RESP;
        if (rd_mapped) begin
          rresp_d = RESP_OKAY;
          case (s_axi.s_araddr[3:2])
            2'd0:    rdata_d = {31'd0, ctrl_en_q};
            2'd1:    rdata_d = status_i;
            2'd2:    rdata_d = count_q;
            default: rdata_d = scratch_q;
          endcase
        end else begin
          rresp_d = RESP_UNMAPPED;
          rdata_d = '0;
        end
      end
      R_RESP:  if (s_axi.s_rready) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  // Bus outputs decoded from FSM state and held registers.
  always_comb begin
    s_axi.s_awready = rdy_en_q && !aw_held_q && (wst_q != W_RESP);
    s_axi.s_wready  = rdy_en_q && !w_held_q  && (wst_q != W_RESP);
    s_axi.s_bvalid  = (wst_q == W_RESP);
    s_axi.s_bresp   = bresp_q;
    s_axi.s_arready = rdy_en_q && (rst_q == R_IDLE);
    s_axi.s_rvalid  = (rst_q == R_RESP);
    s_axi.s_rdata   = rdata_q;
    s_axi.s_rresp   = rresp_q;
    cnt_wrap_o      = wrap_q;
  end

endmodule

// File: tb/tb_axi4_lite_reg_slv.sv
// Bench for axi4_lite_reg_slv: directed scenarios plus randomized accesses against a register model.
module tb_axi4_lite_reg_slv;

`ifdef AXI4_LITE_REG_SLV_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] status_i;
  logic        cnt_wrap_o;

  axi4_lite_reg_slv_if #(.AW(8), .DW(32)) bus ();

  axi4_lite_reg_slv #(.ADDR_BIT_WIDTH(8), .DATA_BIT_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axi      (bus),
    .status_i   (status_i),
    .cnt_wrap_o (cnt_wrap_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned wrap_cnt = 0;
  int unsigned wrap_cyc = 0;
  always @(negedge clk) if (cnt_wrap_o === 1'b1) begin
    wrap_cnt++;
    wrap_cyc = cyc;
  end

  int passed = 0;
  int total  = 0;

  int unsigned last_wr_cyc, last_rd_cyc;
  logic        b_immediate, r_immediate;

  // model state
  logic        m_en;
  logic [31:0] m_count, m_scratch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] strobed(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // model of a write; returns the expected response
  function automatic logic [1:0] model_wr(input logic [7:0] addr, input logic [31:0] data,
                                          input logic [3:0] strb);
    if (addr[7:4] != 4'h0) return UNMAP_RESP;
    case (addr[3:2])
      2'd0: if (strb[0]) begin
        m_en = data[0];
        if (data[1]) m_count = 32'h0;
      end
      2'd2: m_count   = strobed(m_count, data, strb);
      2'd3: m_scratch = strobed(m_scratch, data, strb);
      default: ;
    endcase
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_rd(input logic [7:0] addr);
    if (addr[7:4] != 4'h0) return 32'h0;
    case (addr[3:2])
      2'd0:    return {31'h0, m_en};
      2'd1:    return status_i;
      2'd2:    return m_count;
      default: return m_scratch;
    endcase
  endfunction

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0;
    @(negedge clk);
    bus.s_awaddr = addr; bus.s_awvalid = 1'b1;
    bus.s_wdata = data;  bus.s_wstrb = strb; bus.s_wvalid = 1'b1;
    bus.s_bready = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      @(negedge clk); n++;
      if (aw_hs) begin aw_done = 1; bus.s_awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.s_wvalid = 1'b0; end
    end
    if (!(aw_done && w_done)) chk("wr_addr_data_timeout", 32'(aw_done && w_done), 32'h1);
    last_wr_cyc = cyc;
    b_immediate = bus.s_bvalid;
    n = 0;
    while (!bus.s_bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.s_bvalid) chk("wr_resp_timeout", 32'(bus.s_bvalid), 32'h1);
    resp = bus.s_bresp;
    @(negedge clk);
    bus.s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit done = 0, hs;
    int n = 0;
    @(negedge clk);
    bus.s_araddr = addr; bus.s_arvalid = 1'b1; bus.s_rready = 1'b1;
    while (!done && n < 50) begin
      hs = bus.s_arvalid && bus.s_arready;
      @(negedge clk); n++;
      if (hs) begin done = 1; bus.s_arvalid = 1'b0; end
    end
    if (!done) chk("rd_addr_timeout", 32'(done), 32'h1);
    last_rd_cyc = cyc;
    r_immediate = bus.s_rvalid;
    n = 0;
    while (!bus.s_rvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.s_rvalid) chk("rd_data_timeout", 32'(bus.s_rvalid), 32'h1);
    data = bus.s_rdata;
    resp = bus.s_rresp;
    @(negedge clk);
    bus.s_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, rresp;
    logic [31:0] rdata, rd2;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int unsigned e1, e2, w, wc0;

    rst_n = 1'b0; status_i = 32'h0;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    m_en = 1'b0; m_count = 32'h0; m_scratch = 32'h0;

    // reset state
    repeat (5) @(negedge clk);
    chk("rst_awready", 32'(bus.s_awready), 32'h0);
    chk("rst_wready",  32'(bus.s_wready),  32'h0);
    chk("rst_arready", 32'(bus.s_arready), 32'h0);
    chk("rst_bvalid",  32'(bus.s_bvalid),  32'h0);
    chk("rst_rvalid",  32'(bus.s_rvalid),  32'h0);
    chk("rst_bresp",   32'(bus.s_bresp),   32'h0);
    chk("rst_rresp",   32'(bus.s_rresp),   32'h0);
    chk("rst_rdata",   bus.s_rdata,        32'h0);
    chk("rst_wrap",    32'(cnt_wrap_o),    32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_arready_before_edge", 32'(bus.s_arready), 32'h0);
    @(negedge clk);
    chk("post_rst_awready", 32'(bus.s_awready), 32'h1);
    chk("post_rst_wready",  32'(bus.s_wready),  32'h1);
    chk("post_rst_arready", 32'(bus.s_arready), 32'h1);

    // basic COUNT write/read
    axi_write(8'h08, 32'h0000_0010, 4'hF, resp);
    chk("cnt_wr_resp", 32'(resp), 32'(model_wr(8'h08, 32'h10, 4'hF)));
    chk("cnt_wr_bvalid_next_cycle", 32'(b_immediate), 32'h1);
    axi_read(8'h08, rdata, rresp);
    chk("cnt_rd_data", rdata, model_rd(8'h08));
    chk("cnt_rd_resp", 32'(rresp), 32'h0);
    chk("cnt_rd_rvalid_next_cycle", 32'(r_immediate), 32'h1);

    // W three cycles before AW, B held off for four cycles
    @(negedge clk);
    bus.s_wdata = 32'h5A5A_1234; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1; bus.s_bready = 1'b0;
    @(negedge clk);
    bus.s_wvalid = 1'b0;
    chk("wfirst_wready_low", 32'(bus.s_wready), 32'h0);
    chk("wfirst_awready_high", 32'(bus.s_awready), 32'h1);
    repeat (2) @(negedge clk);
    bus.s_awaddr = 8'h0C; bus.s_awvalid = 1'b1;
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    void'(model_wr(8'h0C, 32'h5A5A_1234, 4'hF));
    for (int i = 0; i < 4; i++) begin
      chk("bhold_bvalid",  32'(bus.s_bvalid),  32'h1);
      chk("bhold_awready", 32'(bus.s_awready), 32'h0);
      chk("bhold_wready",  32'(bus.s_wready),  32'h0);
      if (i < 3) @(negedge clk);
    end
    bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_bready = 1'b0;
    chk("bdone_bvalid",  32'(bus.s_bvalid),  32'h0);
    chk("bdone_awready", 32'(bus.s_awready), 32'h1);
    chk("bdone_wready",  32'(bus.s_wready),  32'h1);
    axi_read(8'h0C, rdata, rresp);
    chk("wfirst_scratch", rdata, model_rd(8'h0C));

    // counter runs for exactly the cycles cnt_en was set
    axi_write(8'h08, 32'd100, 4'hF, resp);
    axi_write(8'h00, 32'h1, 4'hF, resp); e1 = last_wr_cyc;
    axi_write(8'h00, 32'h0, 4'hF, resp); e2 = last_wr_cyc;
    axi_read(8'h08, rdata, rresp);
    chk("cnt_run_span", rdata, 32'd100 + 32'(e2 - e1));

    // COUNT write overrides a running increment
    axi_write(8'h00, 32'h1, 4'hF, resp);
    axi_write(8'h08, 32'h1000, 4'hF, resp); w = last_wr_cyc;
    axi_read(8'h08, rdata, rresp);
    chk("cnt_write_while_run", rdata, 32'h1000 + 32'(last_rd_cyc - w - 1));
    axi_write(8'h00, 32'h0, 4'hF, resp); e2 = last_wr_cyc;
    m_en = 1'b0; m_count = 32'h1000 + 32'(e2 - w);
    axi_read(8'h08, rdata, rresp);
    chk("cnt_stopped", rdata, model_rd(8'h08));

    // wrap pulse and clear
    wc0 = wrap_cnt;
    axi_write(8'h08, 32'hFFFF_FFFE, 4'hF, resp);
    axi_write(8'h00, 32'h1, 4'hF, resp); e1 = last_wr_cyc;
    axi_write(8'h00, 32'h2, 4'hF, resp);
    void'(model_wr(8'h00, 32'h2, 4'hF));
    chk("wrap_count_once", wrap_cnt - wc0, 32'h1);
    chk("wrap_timing", wrap_cyc, e1 + 2);
    axi_read(8'h08, rdata, rresp);
    chk("clr_count_zero", rdata, model_rd(8'h08));
    axi_read(8'h00, rdata, rresp);
    chk("ctrl_rd_after_clr", rdata, model_rd(8'h00));
    axi_write(8'h08, 32'hFFFF_FFFF, 4'hF, resp);
    axi_write(8'h08, 32'h0, 4'hF, resp);
    void'(model_wr(8'h08, 32'h0, 4'hF));
    chk("no_wrap_on_write", wrap_cnt - wc0, 32'h1);

    // byte strobes on SCRATCH, STATUS read-only
    axi_write(8'h0C, 32'hAABB_CCDD, 4'hF, resp); void'(model_wr(8'h0C, 32'hAABB_CCDD, 4'hF));
    axi_write(8'h0C, 32'h1122_3344, 4'h5, resp); void'(model_wr(8'h0C, 32'h1122_3344, 4'h5));
    axi_read(8'h0C, rdata, rresp);
    chk("scratch_strobe", rdata, 32'hAA22_CC44);
    axi_write(8'h04, 32'h1234_5678, 4'hF, resp);
    chk("status_wr_resp", 32'(resp), 32'h0);
    status_i = 32'h0000_CAFE;
    axi_read(8'h04, rdata, rresp);
    chk("status_rd", rdata, 32'h0000_CAFE);

    // unmapped accesses
    axi_write(8'h20, 32'h3, 4'hF, resp);
    chk("unmap_wr_resp", 32'(resp), 32'(UNMAP_RESP));
    axi_write(8'h2C, 32'hDEAD_0000, 4'hF, resp);
    axi_read(8'h20, rdata, rresp);
    chk("unmap_rd_data", rdata, 32'h0);
    chk("unmap_rd_resp", 32'(rresp), 32'(UNMAP_RESP));
    axi_read(8'h0C, rdata, rresp);
    chk("unmap_scratch_kept", rdata, model_rd(8'h0C));
    axi_read(8'h00, rdata, rresp);
    chk("unmap_ctrl_kept", rdata, model_rd(8'h00));

    // same-cycle read and write of SCRATCH: read sees the old value
    rd2 = m_scratch;
    fork
      axi_write(8'h0C, 32'hDEAD_BEEF, 4'hF, resp);
      axi_read(8'h0C, rdata, rresp);
    join
    void'(model_wr(8'h0C, 32'hDEAD_BEEF, 4'hF));
    chk("rw_same_cycle_old", rdata, rd2);
    chk("rw_same_edge", last_rd_cyc, last_wr_cyc);
    axi_read(8'h0C, rdata, rresp);
    chk("rw_after_new", rdata, model_rd(8'h0C));

    // randomized accesses, counter kept stopped
    for (int i = 0; i < 40; i++) begin
      int k;
      k = int'($urandom_range(0, 5));
      if (k < 4) a = 8'(k * 4);
      else       a = 8'(16 * $urandom_range(1, 15));
      a[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        if (a[3:2] == 2'd0) d[0] = 1'b0;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, resp);
        chk("rand_wr_resp", 32'(resp), 32'(model_wr(a, d, s)));
      end else begin
        status_i = $urandom;
        axi_read(a, rdata, rresp);
        chk("rand_rd_data", rdata, model_rd(a));
        chk("rand_rd_resp", 32'(rresp), (a[7:4] != 4'h0) ? 32'(UNMAP_RESP) : 32'h0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
